mem_arbiter: RTL and testbench

- Shares the single 128-bit line-wide memory port between the instruction cache (I) and the data cache (D).
- Each client drives the same request/ready protocol the caches already use toward memory: level-held read/write, 28-bit line address, 128-bit write data, and a one-cycle ready pulse.
- Sits between the two cache instances and the memory model/controller at the top level.
- Serialises transactions: one owner at a time, with registered outputs to memory.

---
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-client line-memory arbiter: serialises I-cache and D-cache transactions onto one port.
// Optional ARB_RR_EN: round-robin tie-break via last_grant instead of fixed D-over-I priority.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned LINE_W = 128
) (
  input  logic              clk,
  input  logic              proc_reset_n,

  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LINE_W-1:0] i_wdata,
  output logic              i_ready,
  output logic [LINE_W-1:0] i_rdata,

  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [LINE_W-1:0] d_rdata,

  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,

  output logic              arb_busy
);

  typedef enum logic [1:0] {StIdle, StGrantI, StGrantD, StRelease} state_e;

  state_e              state_q, state_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                i_req, d_req, pick_d;

`ifdef ARB_RR_EN
  // High when the most recent completed grant went to D.
  logic last_d_q, last_d_d;
`endif

  always_comb begin
    state_d     = state_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef ARB_RR_EN
    last_d_d    = last_d_q;
`endif
    i_req = i_read | i_write;
    d_req = d_read | d_write;
`ifdef ARB_RR_EN
    pick_d = d_req & (~i_req | ~last_d_q);
`else
    pick_d = d_req;
`endif

    unique case (state_q)
      StIdle: begin
        // A simultaneous read and write is treated as a read.
        if (pick_d) begin
          state_d     = StGrantD;
          mem_read_d  = d_read;
          mem_write_d = d_write & ~d_read;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
        end else if (i_req) begin
          state_d     = StGrantI;
          mem_read_d  = i_read;
          mem_write_d = i_write & ~i_read;
          mem_addr_d  = i_addr;
          mem_wdata_d = i_wdata;
        end
      end
      StGrantI: begin
        if (mem_ready) begin
          state_d     = StRelease;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
`ifdef ARB_RR_EN
          last_d_d    = 1'b0;
`endif
        end
      end
      StGrantD: begin
        if (mem_ready) begin
          state_d     = StRelease;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
`ifdef ARB_RR_EN
          last_d_d    = 1'b1;
`endif
        end
      end
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!proc_reset_n) begin
      state_q     <= StIdle;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef ARB_RR_EN
      last_d_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef ARB_RR_EN
      last_d_q    <= last_d_d;
`endif
    end
  end

  // Ready is only forwarded to the current owner; strays in other states are dropped.
  assign i_ready   = (state_q == StGrantI) & mem_ready;
  assign d_ready   = (state_q == StGrantD) & mem_ready;
  assign i_rdata   = mem_rdata;
  assign d_rdata   = mem_rdata;

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign arb_busy  = (state_q == StGrantI) | (state_q == StGrantD);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: per-cycle transaction model plus directed literal checks.
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         proc_reset_n = 1'b1;
  logic         i_read = 1'b0, i_write = 1'b0;
  logic [27:0]  i_addr = '0;
  logic [127:0] i_wdata = '0;
  logic         i_ready;
  logic [127:0] i_rdata;
  logic         d_read = 1'b0, d_write = 1'b0;
  logic [27:0]  d_addr = '0;
  logic [127:0] d_wdata = '0;
  logic         d_ready;
  logic [127:0] d_rdata;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = '0;
  logic         mem_ready = 1'b0;
  logic         arb_busy;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  localparam logic [127:0] A5 = {16{8'hA5}};

  mem_arbiter #(.ADDR_W(28), .LINE_W(128)) dut (
    .clk(clk), .proc_reset_n(proc_reset_n),
    .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_ready(i_ready), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Transaction-level model: owner 0 = none, 1 = I, 2 = D; gap = post-ready dead cycle.
  int           m_owner = 0;
  bit           m_gap   = 1'b0;
  int           m_last  = 1;
  logic         m_read  = 1'b0, m_write = 1'b0;
  logic [27:0]  m_addr  = '0;
  logic [127:0] m_wdata = '0;

  always @(posedge clk) begin : model
    int win;
    win = 0;
    if (!proc_reset_n) begin
      m_owner <= 0; m_gap <= 1'b0; m_last <= 1;
      m_read <= 1'b0; m_write <= 1'b0; m_addr <= '0; m_wdata <= '0;
    end else if (m_owner != 0) begin
      if (mem_ready) begin
        m_read <= 1'b0; m_write <= 1'b0; m_last <= m_owner; m_owner <= 0; m_gap <= 1'b1;
      end
    end else if (m_gap) begin
      m_gap <= 1'b0;
    end else begin
      if ((i_read || i_write) && (d_read || d_write)) begin
`ifdef ARB_RR_EN
        win = (m_last == 1) ? 2 : 1;
`else
        win = 2;
`endif
      end else if (d_read || d_write) win = 2;
      else if (i_read || i_write) win = 1;
      if (win == 2) begin
        m_owner <= 2; m_read <= d_read; m_write <= d_write && !d_read;
        m_addr <= d_addr; m_wdata <= d_wdata;
      end else if (win == 1) begin
        m_owner <= 1; m_read <= i_read; m_write <= i_write && !i_read;
        m_addr <= i_addr; m_wdata <= i_wdata;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("mem_read",  {127'd0, mem_read},  {127'd0, m_read});
      check("mem_write", {127'd0, mem_write}, {127'd0, m_write});
      check("mem_addr",  {100'd0, mem_addr},  {100'd0, m_addr});
      check("mem_wdata", mem_wdata, m_wdata);
      check("arb_busy",  {127'd0, arb_busy},  {127'd0, m_owner != 0});
      check("i_ready",   {127'd0, i_ready},   {127'd0, (m_owner == 1) && mem_ready});
      check("d_ready",   {127'd0, d_ready},   {127'd0, (m_owner == 2) && mem_ready});
      if (i_ready) check("i_rdata", i_rdata, mem_rdata);
      if (d_ready) check("d_rdata", d_rdata, mem_rdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse mem_ready on the latency-th cycle of the grant, then step past the ready edge.
  task automatic serve(input int latency, input logic [127:0] data);
    repeat (latency - 1) tick();
    mem_ready = 1'b1;
    mem_rdata = data;
    #1;
  endtask

  task automatic end_serve();
    tick();
    mem_ready = 1'b0;
  endtask

  initial begin
    logic [27:0] exp_addr;
    // Reset then single I read
    proc_reset_n = 1'b0;
    tick();
    proc_reset_n = 1'b1;
    chk_en = 1'b1;
    check("rst_mem_read", {127'd0, mem_read}, 128'd0);
    check("rst_mem_addr", {100'd0, mem_addr}, 128'd0);
    check("rst_busy", {127'd0, arb_busy}, 128'd0);
    i_read = 1'b1; i_addr = 28'h0000010;
    tick();
    check("t1_mem_read", {127'd0, mem_read}, 128'd1);
    check("t1_mem_addr", {100'd0, mem_addr}, 128'h10);
    serve(3, A5);
    check("t1_i_ready", {127'd0, i_ready}, 128'd1);
    check("t1_i_rdata", i_rdata, A5);
    check("t1_d_ready", {127'd0, d_ready}, 128'd0);
    end_serve();
    i_read = 1'b0;
    check("t1_read_clr", {127'd0, mem_read}, 128'd0);
    check("t1_i_ready_off", {127'd0, i_ready}, 128'd0);
    tick();

    // Simultaneous requests: D first, I after RELEASE+IDLE
    i_read = 1'b1; i_addr = 28'h10;
    d_write = 1'b1; d_addr = 28'h20; d_wdata = 128'h1234;
    tick();
    check("t2_d_write", {127'd0, mem_write}, 128'd1);
    check("t2_d_read", {127'd0, mem_read}, 128'd0);
    check("t2_d_addr", {100'd0, mem_addr}, 128'h20);
    check("t2_d_wdata", mem_wdata, 128'h1234);
    serve(2, 128'h0);
    check("t2_d_ready", {127'd0, d_ready}, 128'd1);
    check("t2_i_ready", {127'd0, i_ready}, 128'd0);
    end_serve();
    d_write = 1'b0;
    tick();
    check("t2_gap_idle", {127'd0, arb_busy}, 128'd0);
    tick();
    check("t2_i_read", {127'd0, mem_read}, 128'd1);
    check("t2_i_addr", {100'd0, mem_addr}, 128'h10);
    serve(2, 128'h77);
    end_serve();
    i_read = 1'b0;
    tick();

    // D fill then writeback: two dead cycles between transactions
    d_read = 1'b1; d_addr = 28'h30;
    tick();
    serve(2, 128'h5555);
    check("t3_d_ready", {127'd0, d_ready}, 128'd1);
    end_serve();
    d_read = 1'b0; d_write = 1'b1; d_addr = 28'h40; d_wdata = 128'hBEEF;
    check("t3_gap1", {127'd0, mem_write}, 128'd0);
    tick();
    check("t3_gap2", {127'd0, mem_write}, 128'd0);
    tick();
    check("t3_wb_write", {127'd0, mem_write}, 128'd1);
    check("t3_wb_addr", {100'd0, mem_addr}, 128'h40);
    serve(2, 128'h0);
    end_serve();
    d_write = 1'b0;
    tick();

    // Input changes while granted are ignored
    i_read = 1'b1; i_addr = 28'h10;
    tick();
    i_addr = 28'h99;
    tick();
    check("t4_addr_hold1", {100'd0, mem_addr}, 128'h10);
    tick();
    check("t4_addr_hold2", {100'd0, mem_addr}, 128'h10);
    serve(1, 128'h42);
    check("t4_i_rdata", i_rdata, 128'h42);
    end_serve();
    i_read = 1'b0;
    tick();

    // I write, then D read+write (treated as read)
    i_write = 1'b1; i_addr = 28'h80; i_wdata = 128'hCAFE_F00D;
    tick();
    check("t5_i_write", {127'd0, mem_write}, 128'd1);
    check("t5_i_wdata", mem_wdata, 128'hCAFE_F00D);
    serve(2, 128'h0);
    end_serve();
    i_write = 1'b0;
    tick();
    d_read = 1'b1; d_write = 1'b1; d_addr = 28'h44;
    tick();
    check("t5_rw_read", {127'd0, mem_read}, 128'd1);
    check("t5_rw_write", {127'd0, mem_write}, 128'd0);
    serve(2, 128'h9);
    end_serve();
    d_read = 1'b0; d_write = 1'b0;
    tick();

    // Reset mid-transaction aborts, late ready dropped
    d_read = 1'b1; d_addr = 28'h50;
    tick();
    tick();
    proc_reset_n = 1'b0;
    d_read = 1'b0;
    tick();
    proc_reset_n = 1'b1;
    mem_ready = 1'b1;
    #1;
    check("t6_d_ready", {127'd0, d_ready}, 128'd0);
    check("t6_mem_read", {127'd0, mem_read}, 128'd0);
    check("t6_mem_addr", {100'd0, mem_addr}, 128'd0);
    check("t6_busy", {127'd0, arb_busy}, 128'd0);
    tick();
    mem_ready = 1'b0;
    check("t6_d_ready2", {127'd0, d_ready}, 128'd0);

    // Continuous tie: RR alternates D,I,D,I; fixed priority gives D only
    i_read = 1'b1; i_addr = 28'h60;
    d_read = 1'b1; d_addr = 28'h70;
    tick();
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_RR_EN
      exp_addr = (k % 2 == 0) ? 28'h70 : 28'h60;
`else
      exp_addr = 28'h70;
`endif
      check($sformatf("t7_grant%0d", k), {100'd0, mem_addr}, {100'd0, exp_addr});
      serve(2, 128'h0);
      end_serve();
      tick();
      tick();
    end
    i_read = 1'b0; d_read = 1'b0;
    tick();
    tick();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
